// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU datapath blocks.
//   - NIBBLE_W     : width of one adder slice (4 bits).
//   - nsa_state_t  : state encoding of the nibble-serial adder sequencer
//                    (NSA_IDLE=0, NSA_RUN=1, NSA_DONE=2).
//   - nsa_overflow : two's-complement overflow rule for an addition whose
//                    second operand has already been conditionally inverted.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        NSA_IDLE = 2'd0,
        NSA_RUN  = 2'd1,
        NSA_DONE = 2'd2
    } nsa_state_t;

    // Overflow happens when both addends share a sign and the sum's sign differs.
    function automatic logic nsa_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder_4.sv
// ---------------------------------------------------------------------------
// full_adder_4
//   4-bit ripple-carry adder slice, purely combinational.
//   Ports:
//     S   : output [3:0] sum bits
//     C_O : output       carry out of bit 3
//     A   : input  [3:0] addend A
//     B   : input  [3:0] addend B
//     C_I : input        carry into bit 0
// ---------------------------------------------------------------------------
module full_adder_4 (
    output logic [3:0] S,
    output logic       C_O,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_I
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = C_I;
        for (int i = 0; i < 4; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        C_O = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Iterative WIDTH-bit adder/subtractor that reuses a single full_adder_4
//   slice, one nibble per clock, least significant nibble first.
//
//   Parameters:
//     WIDTH     : operand/result width, a multiple of 4 and at least 8.
//
//   Ports:
//     clk       : input        rising-edge clock
//     rst       : input        asynchronous active-high reset
//     start     : input        request an operation (ignored while busy)
//     sub       : input        0 = a+b, 1 = a-b (captured with start)
//     a, b      : input  [W]   operands (captured with start)
//     busy      : output       operation in progress
//     done      : output       one-cycle pulse, result and flags valid
//     result    : output [W]   sum/difference, held until the next start
//     carry_out : output       MSB-nibble carry (for sub: 1 = no borrow)
//     overflow  : output       two's-complement signed overflow
//     zero      : output       result == 0 (only with NSA_ZERO_FLAG_EN)
//
//   Build option:
//     NSA_ZERO_FLAG_EN : when defined, adds the zero output and its detector.
//
//   Handshake: start is accepted on any rising edge where busy=0 (IDLE or
//   DONE state); the operands and sub are captured on that edge. busy is
//   high for the WIDTH/4 cycles that follow, then done pulses high for
//   exactly one cycle. A start during busy is dropped without touching the
//   captured operands; a start during the done cycle begins the next
//   operation immediately.
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
`ifdef NSA_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int STEP_W  = $clog2(NIBBLES);
    localparam int IDX_W   = STEP_W + 2;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIBBLES - 1);

    nsa_state_t state;
    nsa_state_t state_next;

    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;      // already inverted for subtraction
    logic                carry_q;
    logic [STEP_W-1:0]   step;

    logic                accept;
    logic                last_step;
    logic [IDX_W-1:0]    bit_idx;
    logic [3:0]          slice_a;
    logic [3:0]          slice_b;
    logic [3:0]          slice_s;
    logic                slice_co;
    logic [WIDTH-1:0]    result_shift;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign accept    = start && (state != NSA_RUN);
    assign last_step = (state == NSA_RUN) && (step == LAST_STEP);
    assign busy      = (state == NSA_RUN);
    assign done      = (state == NSA_DONE);

    // Bit offset of the current nibble: step * 4.
    assign bit_idx = {step, 2'b00};
    assign slice_a = a_q[bit_idx +: NIBBLE_W];
    assign slice_b = b_q[bit_idx +: NIBBLE_W];

    // New nibble enters at the top; after the last step the first nibble
    // has travelled down to bit 0.
    assign result_shift = {slice_s, result[WIDTH-1:NIBBLE_W]};

    full_adder_4 u_slice (
        .S   (slice_s),
        .C_O (slice_co),
        .A   (slice_a),
        .B   (slice_b),
        .C_I (carry_q)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NSA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            NSA_IDLE: begin
                if (start) begin
                    state_next = NSA_RUN;
                end
            end
            NSA_RUN: begin
                if (step == LAST_STEP) begin
                    state_next = NSA_DONE;
                end
            end
            NSA_DONE: begin
                state_next = start ? NSA_RUN : NSA_IDLE;
            end
            default: begin
                state_next = NSA_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture, step counter, carry and result shift register.
    // Subtraction is a + ~b + 1: b is inverted at capture and the +1 is
    // the initial carry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            step      <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            step    <= '0;
        end else if (state == NSA_RUN) begin
            result  <= result_shift;
            carry_q <= slice_co;
            step    <= step + 1'b1;
            if (last_step) begin
                carry_out <= slice_co;
                overflow  <= nsa_overflow(a_q[WIDTH-1], b_q[WIDTH-1], slice_s[3]);
            end
        end
    end

`ifdef NSA_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
        end else if (last_step) begin
            zero <= (result_shift == '0);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
`ifdef NSA_ZERO_FLAG_EN
    logic         zero;
`endif

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
`ifdef NSA_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // entry = {overflow, carry_out, result}
    logic [W+1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic [W-1:0] yy;
        logic [W:0]   t;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        return {(x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]), t[W], t[W-1:0]};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [W+1:0] exp, input bit push);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen at a negedge.
    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [W+1:0] e;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done_timeout: got done=%0b expected 1", tag, done);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue_empty: got 0 entries expected 1", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'(result), 64'(e[W-1:0]));
            check({tag, "_carry"}, 64'(carry_out), 64'(e[W]));
            check({tag, "_ovf"}, 64'(overflow), 64'(e[W+1]));
`ifdef NSA_ZERO_FLAG_EN
            check({tag, "_zero"}, 64'(zero), 64'(e[W-1:0] == '0));
`endif
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_carry"}, 64'(carry_out), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
`ifdef NSA_ZERO_FLAG_EN
        check({tag, "_zero"}, 64'(zero), 64'd0);
`endif
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int busy_n;
        int done_cnt;
        logic [W-1:0] held;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        for (int i = 6; i < 12; i++) begin
            logic [W+1:0] m;
            vecs[i].a   = $urandom;
            vecs[i].b   = $urandom;
            vecs[i].sub = 1'($urandom_range(0, 1));
            m = model(vecs[i].a, vecs[i].b, vecs[i].sub);
            vecs[i].r = m[W-1:0];
            vecs[i].c = m[W];
            vecs[i].o = m[W+1];
        end

        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // table-driven operations
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, {vecs[i].o, vecs[i].c, vecs[i].r}, 1'b1);
            wait_done(n, busy_n);
            check($sformatf("v%0d_latency", i), 64'(n + 1), 64'd9);
            check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'd8);
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            pop_compare($sformatf("v%0d", i));
            held = result;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("v%0d_result_hold", i), 64'(result), 64'(held));
        end

        // start while busy is ignored
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 1'b0, 32'h2345_6789}, 1'b1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        a     = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        done_cnt = 0;
        wait_done(n, busy_n);
        check("ign_latency", 64'(n + 5), 64'd9);
        if (done) done_cnt++;
        pop_compare("ign");
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("ign_done_count", 64'(done_cnt), 64'd1);
        check("ign_busy_after", 64'(busy), 64'd0);

        // back-to-back: start in the done cycle
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, model(32'h0000_00FF, 32'h0000_0001, 1'b0), 1'b1);
        wait_done(n, busy_n);
        pop_compare("b2b_first");
        issue(32'h0000_0010, 32'h0000_0020, 1'b1, model(32'h0000_0010, 32'h0000_0020, 1'b1), 1'b1);
        check("b2b_done_once", 64'(done), 64'd0);
        check("b2b_busy_again", 64'(busy), 64'd1);
        wait_done(n, busy_n);
        check("b2b_latency", 64'(n + 1), 64'd9);
        pop_compare("b2b_second");
        @(posedge clk);
        @(negedge clk);

        // reset in the middle of an operation
        issue(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, '0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0000_0002}, 1'b1);
        wait_done(n, busy_n);
        check("post_rst_latency", 64'(n + 1), 64'd9);
        pop_compare("post_rst");

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
